carbon_mmio_ctrl: RTL and testbench

Parametrised system MMIO controller that replaces the fixed signature/poweroff/UART-TX offset constants with a live register block behind a valid/ready request/response port. It sits behind the system-top address decoder, with one instance per system class (SYS16, SYSX86) configured by parameters. It adds a buffered UART TX path with a FIFO, a status register, a scratch register, sticky overflow reporting and decode-error responses.

---
 rtl/carbon_memmap_pkg.sv | 36 +++
 rtl/carbon_sync_fifo.sv | 49 ++++
 rtl/carbon_mmio_ctrl.sv | 164 ++++++++++++++++
 tb/tb_carbon_mmio_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carbon_memmap_pkg.sv
// Shared system memory-map definitions: MMIO register offsets, signature value,
// status register layout and the register decode selector.
package carbon_memmap_pkg;

    localparam logic [7:0] CARBON_MMIO_SIG_OFF       = 8'h00;
    localparam logic [7:0] CARBON_MMIO_POWEROFF_OFF  = 8'h04;
    localparam logic [7:0] CARBON_MMIO_UART_TX_OFF   = 8'h08;
    localparam logic [7:0] CARBON_MMIO_UART_STAT_OFF = 8'h0C;
    localparam logic [7:0] CARBON_MMIO_SCRATCH_OFF   = 8'h10;

    localparam logic [31:0] CARBON_MMIO_SIGNATURE_VAL = 32'h4341_5242;

    localparam int unsigned CARBON_MMIO_STAT_FULL_BIT  = 0;
    localparam int unsigned CARBON_MMIO_STAT_EMPTY_BIT = 1;
    localparam int unsigned CARBON_MMIO_STAT_OVF_BIT   = 2;
    localparam int unsigned CARBON_MMIO_STAT_LEVEL_LSB = 8;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  level;
        logic [4:0]  rsvd_lo;
        logic        overflow;
        logic        empty;
        logic        full;
    } carbon_mmio_status_t;

    typedef enum logic [2:0] {
        REG_SIG,
        REG_POWEROFF,
        REG_UART_TX,
        REG_UART_STAT,
        REG_SCRATCH,
        REG_NONE
    } carbon_mmio_reg_e;

endpackage

// File: rtl/carbon_sync_fifo.sv
// Single-clock circular FIFO with extra-MSB pointers; head entry is read
// combinationally so the consumer sees data in the same cycle it becomes valid.
module carbon_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level    = wptr - rptr;
    assign pop_data = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // full/empty come from registered pointers, so a same-cycle pop
            // never makes room for a push into a full FIFO
            if (push && !full) begin
                mem[wptr[AW-1:0]] <= push_data;
                wptr              <= wptr + 1'b1;
            end
            if (pop && !empty) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/carbon_mmio_ctrl.sv
// System MMIO register block: signature, power-off, buffered UART TX, status and
// scratch registers behind a single-outstanding valid/ready request/response port.
module carbon_mmio_ctrl
    import carbon_memmap_pkg::*;
#(
    parameter int unsigned       ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] MMIO_BASE     = 32'h0000_F000,
    parameter logic [ADDR_W-1:0] MMIO_MASK     = 32'hFFFF_FF00,
    parameter logic [31:0]       SIGNATURE     = CARBON_MMIO_SIGNATURE_VAL,
    parameter int unsigned       TX_DEPTH      = 8,
    parameter bit                STALL_ON_FULL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              poweroff_req,
    output logic [7:0]        poweroff_code
);

    localparam int unsigned LVL_W = $clog2(TX_DEPTH) + 1;

    logic [ADDR_W-1:0]   offset;
    carbon_mmio_reg_e    sel_reg;
    logic                accept;
    logic                tx_write;
    logic                stall;
    logic                fifo_push;
    logic                fifo_full;
    logic                fifo_empty;
    logic [LVL_W-1:0]    fifo_level;
    logic                overflow;
    logic [31:0]         scratch;
    logic [31:0]         rdata_next;
    logic                err_next;
    carbon_mmio_status_t status;

    assign offset = req_addr & ~MMIO_MASK & {{(ADDR_W-2){1'b1}}, 2'b00};

    always_comb begin
        sel_reg = REG_NONE;
        if ((req_addr & MMIO_MASK) == MMIO_BASE) begin
            case (offset)
                ADDR_W'(CARBON_MMIO_SIG_OFF):       sel_reg = REG_SIG;
                ADDR_W'(CARBON_MMIO_POWEROFF_OFF):  sel_reg = REG_POWEROFF;
                ADDR_W'(CARBON_MMIO_UART_TX_OFF):   sel_reg = REG_UART_TX;
                ADDR_W'(CARBON_MMIO_UART_STAT_OFF): sel_reg = REG_UART_STAT;
                ADDR_W'(CARBON_MMIO_SCRATCH_OFF):   sel_reg = REG_SCRATCH;
                default:                            sel_reg = REG_NONE;
            endcase
        end
    end

    assign tx_write  = req_valid && req_write && (sel_reg == REG_UART_TX) && req_wstrb[0];
    assign stall     = STALL_ON_FULL && tx_write && fifo_full;
    // a response being consumed this cycle frees the slot for a new accept
    assign req_ready = !(rsp_valid && !rsp_ready) && !stall;
    assign accept    = req_valid && req_ready;
    assign fifo_push = accept && tx_write && !fifo_full;

    always_comb begin
        status          = '0;
        status.full     = fifo_full;
        status.empty    = fifo_empty;
        status.overflow = overflow;
        status.level    = 8'(fifo_level);
    end

    always_comb begin
        rdata_next = '0;
        err_next   = (sel_reg == REG_NONE);
        if (!req_write) begin
            case (sel_reg)
                REG_SIG:       rdata_next = SIGNATURE;
                REG_POWEROFF:  rdata_next = {16'h0, poweroff_code, 7'h0, poweroff_req};
                REG_UART_STAT: rdata_next = status;
                REG_SCRATCH:   rdata_next = scratch;
                default:       rdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            poweroff_req  <= 1'b0;
            poweroff_code <= '0;
            overflow      <= 1'b0;
            scratch       <= '0;
        end else begin
            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= rdata_next;
                rsp_err   <= err_next;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end

            if (accept && req_write) begin
                case (sel_reg)
                    REG_POWEROFF: begin
                        if (!poweroff_req && req_wstrb[0] && req_wdata[0]) begin
                            poweroff_req <= 1'b1;
                            if (req_wstrb[1]) begin
                                poweroff_code <= req_wdata[15:8];
                            end
                        end
                    end
                    REG_UART_TX: begin
                        if (!STALL_ON_FULL && req_wstrb[0] && fifo_full) begin
                            overflow <= 1'b1;
                        end
                    end
                    REG_UART_STAT: begin
                        if (req_wstrb[0] && req_wdata[2]) begin
                            overflow <= 1'b0;
                        end
                    end
                    REG_SCRATCH: begin
                        for (int unsigned i = 0; i < 4; i++) begin
                            if (req_wstrb[i]) begin
                                scratch[8*i +: 8] <= req_wdata[8*i +: 8];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    carbon_sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (req_wdata[7:0]),
        .pop       (tx_ready),
        .pop_data  (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign tx_valid = !fifo_empty;

endmodule

// File: tb/tb_carbon_mmio_ctrl.sv
// Bench for carbon_mmio_ctrl: one stalling and one dropping instance, a directed
// register-access vector table and hand-written FIFO/handshake sequences.
module tb_carbon_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_ready = 1'b0;
    logic        tx_ready  = 1'b0;

    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_tx_valid, a_po_req;
    logic [31:0] a_rsp_rdata;
    logic [7:0]  a_tx_data, a_po_code;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_tx_valid, b_po_req;
    logic [31:0] b_rsp_rdata;
    logic [7:0]  b_tx_data, b_po_code;

    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    always #5 clk = ~clk;

    carbon_mmio_ctrl #(.STALL_ON_FULL(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel), .req_ready(a_req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready && !sel),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .tx_valid(a_tx_valid), .tx_ready(tx_ready), .tx_data(a_tx_data),
        .poweroff_req(a_po_req), .poweroff_code(a_po_code)
    );

    carbon_mmio_ctrl #(.STALL_ON_FULL(1'b0)) dut_drop (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel), .req_ready(b_req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready && sel),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .tx_valid(b_tx_valid), .tx_ready(tx_ready), .tx_data(b_tx_data),
        .poweroff_req(b_po_req), .poweroff_code(b_po_code)
    );

    assign m_req_ready = sel ? b_req_ready : a_req_ready;
    assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign m_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;

    // a byte is popped at the next posedge when valid and ready hold mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (a_tx_valid && tx_ready) q_a.push_back(a_tx_data);
            if (b_tx_valid && tx_ready) q_b.push_back(b_tx_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input logic [3:0] ws, input bit pulse,
                          output logic [31:0] rd, output logic er, output int waited);
        req_addr = addr; req_write = wr; req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
        if (pulse) tx_ready = 1'b1;
        waited = 0;
        rd = '0; er = 1'b1;
        @(negedge clk);
        while (!m_req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!m_req_ready) begin
            n_tests++; n_fail++;
            $display("FAIL req_timeout: req_ready=0 after %0d cycles, expected 1", waited);
            req_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (pulse) tx_ready = 1'b0;
        @(negedge clk);
        chk("rsp_valid_after_accept", 32'(m_rsp_valid), 32'd1);
        rd = m_rsp_rdata;
        er = m_rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic drain(input bit use_b);
        int k;
        k = 0;
        tx_ready = 1'b1;
        while ((use_b ? b_tx_valid : a_tx_valid) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_done", 32'(use_b ? b_tx_valid : a_tx_valid), 32'd0);
        tx_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic chk_queue(input string name, input bit use_b, input logic [7:0] first, input int n);
        int sz;
        sz = use_b ? q_b.size() : q_a.size();
        chk({name, "_count"}, 32'(sz), 32'(n));
        for (int i = 0; i < n; i++) begin
            logic [31:0] act;
            act = 32'hFFFF_FFFF;
            if (i < sz) act = 32'(use_b ? q_b[i] : q_a[i]);
            chk($sformatf("%s_byte%0d", name, i), act, 32'(first + 8'(i)));
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w;
        bit          done;

        vecs.push_back('{32'h0000_F000, 1'b0, 32'h0,         4'h0, 32'h4341_5242, 1'b0});
        vecs.push_back('{32'h0000_F014, 1'b0, 32'h0,         4'h0, 32'h0,         1'b1});
        vecs.push_back('{32'h0000_E000, 1'b0, 32'h0,         4'h0, 32'h0,         1'b1});
        vecs.push_back('{32'h0000_F003, 1'b0, 32'h0,         4'h0, 32'h4341_5242, 1'b0});
        vecs.push_back('{32'h0000_F000, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b0});
        vecs.push_back('{32'h0000_F000, 1'b0, 32'h0,         4'h0, 32'h4341_5242, 1'b0});
        vecs.push_back('{32'h0000_F010, 1'b0, 32'h0,         4'h0, 32'h0,         1'b0});
        vecs.push_back('{32'h0000_F010, 1'b1, 32'h1122_3344, 4'hF, 32'h0,         1'b0});
        vecs.push_back('{32'h0000_F010, 1'b0, 32'h0,         4'h0, 32'h1122_3344, 1'b0});
        vecs.push_back('{32'h0000_F010, 1'b1, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0});
        vecs.push_back('{32'h0000_F010, 1'b0, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0});
        vecs.push_back('{32'h0000_F00C, 1'b0, 32'h0,         4'h0, 32'h0000_0002, 1'b0});
        vecs.push_back('{32'h0000_F004, 1'b0, 32'h0,         4'h0, 32'h0,         1'b0});
        vecs.push_back('{32'h0000_F008, 1'b0, 32'h0,         4'h0, 32'h0,         1'b0});
        vecs.push_back('{32'h0000_F014, 1'b1, 32'h1234_5678, 4'hF, 32'h0,         1'b1});
        vecs.push_back('{32'h0000_F100, 1'b0, 32'h0,         4'h0, 32'h0,         1'b1});
        vecs.push_back('{32'h0000_F008, 1'b1, 32'h0000_0055, 4'h2, 32'h0,         1'b0});
        vecs.push_back('{32'h0000_F00C, 1'b0, 32'h0,         4'h0, 32'h0000_0002, 1'b0});
        vecs.push_back('{32'h0000_F010, 1'b0, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0});

        // reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_req_ready", 32'(a_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rsp_rdata", a_rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(a_rsp_err), 32'd0);
        chk("rst_tx_valid", 32'(a_tx_valid), 32'd0);
        chk("rst_tx_data", 32'(a_tx_data), 32'd0);
        chk("rst_po_req", 32'(a_po_req), 32'd0);
        chk("rst_po_code", 32'(a_po_code), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // register map vectors
        foreach (vecs[i]) begin
            do_req(vecs[i].addr, vecs[i].wr, vecs[i].wd, vecs[i].ws, 1'b0, rd, er, w);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
        end

        // power-off: set, sticky, cleared only by reset
        do_req(32'hF004, 1'b1, 32'h0000_2A01, 4'b0011, 1'b0, rd, er, w);
        chk("po_req_set", 32'(a_po_req), 32'd1);
        chk("po_code_set", 32'(a_po_code), 32'h2A);
        do_req(32'hF004, 1'b0, 32'h0, 4'h0, 1'b0, rd, er, w);
        chk("po_readback", rd, 32'h0000_2A01);
        do_req(32'hF004, 1'b1, 32'h0, 4'hF, 1'b0, rd, er, w);
        chk("po_req_sticky", 32'(a_po_req), 32'd1);
        chk("po_code_sticky", 32'(a_po_code), 32'h2A);
        do_req(32'hF004, 1'b1, 32'h0000_5501, 4'b0011, 1'b0, rd, er, w);
        chk("po_code_relatch", 32'(a_po_code), 32'h2A);
        rst = 1'b1;
        #1;
        chk("po_req_reset", 32'(a_po_req), 32'd0);
        chk("po_code_reset", 32'(a_po_code), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // reset while a response is pending
        req_addr = 32'hF000; req_write = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_pending", 32'(a_rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("midrst_rsp_rdata", a_rsp_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // response held under backpressure, then back-to-back accept on handshake
        do_req(32'hF010, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, er, w);
        req_addr = 32'hF000; req_write = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_addr = 32'hF010;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_rsp_valid", c), 32'(a_rsp_valid), 32'd1);
            chk($sformatf("hold%0d_rsp_rdata", c), a_rsp_rdata, 32'h4341_5242);
            chk($sformatf("hold%0d_req_ready", c), 32'(a_req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("b2b_req_ready", 32'(a_req_ready), 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_rsp_valid", 32'(a_rsp_valid), 32'd1);
        chk("b2b_rsp_rdata", a_rsp_rdata, 32'hDEAD_BEEF);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("b2b_rsp_done", 32'(a_rsp_valid), 32'd0);
        @(posedge clk); #1;
        do_req(32'hF010, 1'b1, 32'h1234_5678, 4'b0101, 1'b0, rd, er, w);
        do_req(32'hF010, 1'b0, 32'h0, 4'h0, 1'b0, rd, er, w);
        chk("scratch_lanes", rd, 32'hDE34_BE78);

        // stall on full FIFO
        q_a.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_req(32'hF008, 1'b1, 32'(8'h41 + 8'(i)), 4'h1, 1'b0, rd, er, w);
            chk($sformatf("stall_fill%0d_wait", i), 32'(w), 32'd0);
        end
        req_addr = 32'hF008; req_write = 1'b1; req_wdata = 32'h49; req_wstrb = 4'h1; req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_req_ready", c), 32'(a_req_ready), 32'd0);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(negedge clk);
        chk("stall_before_pop", 32'(a_req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_after_pop", 32'(a_req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("stall_rsp_valid", 32'(a_rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drain(1'b0);
        chk_queue("stall_order", 1'b0, 8'h41, 9);

        // simultaneous push and pop at level 3
        q_a.delete();
        for (int i = 0; i < 3; i++) begin
            do_req(32'hF008, 1'b1, 32'(8'h10 + 8'(i)), 4'h1, 1'b0, rd, er, w);
        end
        do_req(32'hF00C, 1'b0, 32'h0, 4'h0, 1'b0, rd, er, w);
        chk("lvl3_status", rd, 32'h0000_0300);
        do_req(32'hF008, 1'b1, 32'h13, 4'h1, 1'b1, rd, er, w);
        chk("pushpop_wait", 32'(w), 32'd0);
        do_req(32'hF00C, 1'b0, 32'h0, 4'h0, 1'b0, rd, er, w);
        chk("pushpop_status", rd, 32'h0000_0300);
        drain(1'b0);
        chk_queue("pushpop_order", 1'b0, 8'h10, 4);

        // pointer wrap with random consumer backpressure
        q_a.delete();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    do_req(32'hF008, 1'b1, 32'(8'h60 + 8'(i)), 4'h1, 1'b0, rd, er, w);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    if (!done) tx_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain(1'b0);
        chk_queue("wrap_order", 1'b0, 8'h60, 20);

        // drop-on-full instance
        sel = 1'b1;
        q_b.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_req(32'hF008, 1'b1, 32'(8'h41 + 8'(i)), 4'h1, 1'b0, rd, er, w);
            chk($sformatf("drop%0d_wait", i), 32'(w), 32'd0);
        end
        do_req(32'hF00C, 1'b0, 32'h0, 4'h0, 1'b0, rd, er, w);
        chk("drop_status_ovf", rd, 32'h0000_0805);
        do_req(32'hF00C, 1'b1, 32'h4, 4'h1, 1'b0, rd, er, w);
        do_req(32'hF00C, 1'b0, 32'h0, 4'h0, 1'b0, rd, er, w);
        chk("drop_status_clr", rd, 32'h0000_0801);
        do_req(32'hF008, 1'b1, 32'h4A, 4'h1, 1'b1, rd, er, w);
        chk("drop_pop_same_cycle_wait", 32'(w), 32'd0);
        do_req(32'hF00C, 1'b0, 32'h0, 4'h0, 1'b0, rd, er, w);
        chk("drop_pop_same_cycle", rd, 32'h0000_0704);
        drain(1'b1);
        chk_queue("drop_order", 1'b1, 8'h41, 8);
        do_req(32'hF00C, 1'b0, 32'h0, 4'h0, 1'b0, rd, er, w);
        chk("drop_status_empty", rd, 32'h0000_0006);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
